mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Sequential multiply-accumulate controller that wraps the existing combinational array multiplier (`multiple`, WIDTH-bit × WIDTH-bit → 2·WIDTH-bit). It accepts operand pairs over a valid/ready handshake, registers them onto the multiplier inputs, and adds each returned product into an accumulator. After COUNT products it presents the sum on a second valid/ready handshake. It sits directly upstream and downstream of the multiplier: it feeds the multiplier's operands and consumes its product.

## Interface
- WIDTH, 4, operand width; the multiplier instance uses the same value.
- COUNT, 4, number of products per accumulation batch; must be ≥ 1.
- ACC_WIDTH, 10, accumulator width; 2·WIDTH + clog2(COUNT) guarantees no overflow.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept an operand pair.
- i_op1, i_op2  input  WIDTH  operands; sampled only on the handshake edge.
- o_mult_op1, o_mult_op2  output  WIDTH  registered operands driving the multiplier inputs.
- i_mult  input  2·WIDTH  product returned by the multiplier.
- o_acc  output  ACC_WIDTH  accumulated sum.
- o_acc_valid  output  1  o_acc holds a completed batch.
- i_acc_ready  input  1  consumer accepts o_acc.
- o_overflow  output  1  sticky flag; set when any addition in the batch carries out of ACC_WIDTH.

## Operation
- FSM states: S_IDLE, S_ADD, S_DONE. Reset state is S_IDLE.
- o_ready = 1 only in S_IDLE. o_acc_valid = 1 only in S_DONE. Both are decoded from the state register.
- S_IDLE: on i_valid && o_ready, latch i_op1 → o_mult_op1 and i_op2 → o_mult_op2, then go to S_ADD. If i_valid is low, stay in S_IDLE and hold all registers.
- S_ADD:
  - acc ← acc + zero-extend(i_mult) to ACC_WIDTH, modulo 2^ACC_WIDTH.
  - Carry-out from that addition ORs into o_overflow.
  - If cnt == COUNT−1: cnt ← 0, go to S_DONE. Otherwise cnt ← cnt+1, go to S_IDLE.
- S_DONE:
  - Hold o_acc and o_overflow stable.
  - On i_acc_ready: acc ← 0, o_overflow ← 0, go to S_IDLE.
  - i_valid is ignored, because o_ready = 0.
- cnt width is clog2(COUNT), minimum 1 bit. COUNT = 1 means every S_ADD goes directly to S_DONE.
- o_mult_op1/o_mult_op2 keep the last latched pair until the next accepted handshake.
- Reset (any state, any cycle, asynchronous): state ← S_IDLE; acc, cnt, o_overflow, o_mult_op1, o_mult_op2 ← 0. Any partial batch is discarded. Outputs after reset: o_ready = 1, o_acc_valid = 0, o_acc = 0, o_overflow = 0.

## Timing
- Throughput: one operand pair per 2 cycles (S_IDLE → S_ADD).
- Back-to-back with i_valid held high: a batch is accepted in 2·COUNT cycles.
- Latency:
  - A pair accepted on edge t is on the multiplier inputs after edge t.
  - Its product is added on edge t+1.
  - For the last pair of a batch, o_acc_valid goes high after edge t+1 and stays high until the edge where i_acc_ready is sampled high.
- Result handshake on edge u: o_acc_valid = 0 and o_ready = 1 after edge u. The earliest next operand accept is edge u+1.
- i_mult must settle within one cycle of o_mult_op changes. The multiplier is combinational, so there is no extra pipeline stage.
- Gaps (i_valid low) between pairs are allowed at any point in a batch and do not affect cnt or acc.

## Test plan
- Basic batch, defaults: pairs (3,5), (7,2), (15,15), (1,0) with i_acc_ready = 1 → o_acc = 254, o_overflow = 0. o_acc_valid is high for exactly 1 cycle, starting 2 cycles after the 4th accept.
- Maximum values, defaults: 4 × (15,15) → o_acc = 900, o_overflow = 0. Repeat the batch immediately → 900 again, confirming acc clears on the result handshake.
- Overflow, ACC_WIDTH = 8, COUNT = 2: (15,15), (15,15) → o_acc = 194, o_overflow = 1. The next batch (1,1), (1,1) → o_acc = 2, o_overflow = 0.
- Backpressure: complete a batch, hold i_acc_ready = 0 for 5 cycles while driving i_valid = 1 with (9,9). Required: o_acc stable, o_ready = 0, no accept. Then raise i_acc_ready → return to S_IDLE, and (9,9) is accepted the following cycle.
- Gapped input: the basic batch with 3 idle cycles between each pair → o_acc = 254, with no extra accepts counted.
- Reset mid-batch: after 2 pairs are accepted, pulse i_rst asynchronously, away from a clock edge. Required: o_mult_op1/o_mult_op2 = 0, o_ready = 1 immediately. A fresh batch of 4 × (1,1) → o_acc = 4.

Source files
------------

// File: rtl/mac_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_accumulator : valid/ready multiply-accumulate controller that drives an
// external combinational multiplier and sums COUNT products per batch.
// Revision 1.0
// ---------------------------------------------------------------------------
module mac_accumulator #(
    parameter int WIDTH     = 4,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_op1,
    input  logic [WIDTH-1:0]       i_op2,
    output logic [WIDTH-1:0]       o_mult_op1,
    output logic [WIDTH-1:0]       o_mult_op2,
    input  logic [2*WIDTH-1:0]     i_mult,
    output logic [ACC_WIDTH-1:0]   o_acc,
    output logic                   o_acc_valid,
    input  logic                   i_acc_ready,
    output logic                   o_overflow
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [SUM_W-1:0]       sum;

    // One extra bit captures the carry-out that feeds the sticky overflow flag.
    assign sum = {1'b0, acc} + SUM_W'(i_mult);

    assign o_ready     = (state == S_IDLE);
    assign o_acc_valid = (state == S_DONE);
    assign o_acc       = acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            o_overflow <= 1'b0;
            o_mult_op1 <= '0;
            o_mult_op2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_mult_op1 <= i_op1;
                        o_mult_op2 <= i_op2;
                        state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc        <= sum[ACC_WIDTH-1:0];
                    o_overflow <= o_overflow | sum[ACC_WIDTH];
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (i_acc_ready) begin
                        acc        <= '0;
                        o_overflow <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_accumulator : directed + randomized bench for mac_accumulator with a
// default instance (A) and an 8-bit-accumulator, COUNT=2 instance (B).
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_a, valid_b, acc_ready;
    logic [3:0] op1, op2;

    logic       rdy_a, accv_a, ov_a;
    logic [3:0] mop1_a, mop2_a;
    logic [7:0] mult_a;
    logic [9:0] acc_a;

    logic       rdy_b, accv_b, ov_b;
    logic [3:0] mop1_b, mop2_b;
    logic [7:0] mult_b;
    logic [7:0] acc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational array multiplier.
    assign mult_a = {4'b0, mop1_a} * {4'b0, mop2_a};
    assign mult_b = {4'b0, mop1_b} * {4'b0, mop2_b};

    mac_accumulator #(.WIDTH(4), .COUNT(4), .ACC_WIDTH(10)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .o_ready(rdy_a),
        .i_op1(op1), .i_op2(op2), .o_mult_op1(mop1_a), .o_mult_op2(mop2_a),
        .i_mult(mult_a), .o_acc(acc_a), .o_acc_valid(accv_a),
        .i_acc_ready(acc_ready), .o_overflow(ov_a)
    );

    mac_accumulator #(.WIDTH(4), .COUNT(2), .ACC_WIDTH(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .o_ready(rdy_b),
        .i_op1(op1), .i_op2(op2), .o_mult_op1(mop1_b), .o_mult_op2(mop2_b),
        .i_mult(mult_b), .o_acc(acc_b), .o_acc_valid(accv_b),
        .i_acc_ready(acc_ready), .o_overflow(ov_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one pair after 'gap' idle cycles; returns on the negedge after the accept.
    task automatic send(input bit b, input int x, input int y, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        while ((b ? rdy_b : rdy_a) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", b ? rdy_b : rdy_a, 1);
        op1 = 4'(x);
        op2 = 4'(y);
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        chk("mult_op1", b ? mop1_b : mop1_a, x);
        chk("mult_op2", b ? mop2_b : mop2_a, y);
    endtask

    task automatic get_result(input bit b, input int exp_acc, input int exp_ov, input int delay);
        int n = 0;
        while ((b ? accv_b : accv_a) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("acc_valid", b ? accv_b : accv_a, 1);
        chk("acc", b ? 32'(acc_b) : 32'(acc_a), exp_acc);
        chk("overflow", b ? ov_b : ov_a, exp_ov);
        chk("ready_in_done", b ? rdy_b : rdy_a, 0);
        repeat (delay) begin
            @(negedge clk);
            chk("acc_hold", b ? 32'(acc_b) : 32'(acc_a), exp_acc);
            chk("acc_valid_hold", b ? accv_b : accv_a, 1);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("acc_valid_clear", b ? accv_b : accv_a, 0);
        chk("acc_clear", b ? 32'(acc_b) : 32'(acc_a), 0);
        chk("overflow_clear", b ? ov_b : ov_a, 0);
        chk("ready_after", b ? rdy_b : rdy_a, 1);
    endtask

    // Reference: result is the plain sum of products reduced mod 2^aw;
    // the sticky flag is set exactly when that true sum reaches 2^aw.
    task automatic batch(input bit b, input int xs[4], input int ys[4], input int n,
                         input int gap, input int delay);
        int total = 0;
        int aw    = b ? 8 : 10;
        for (int i = 0; i < n; i++) begin
            send(b, xs[i], ys[i], gap);
            total += xs[i] * ys[i];
        end
        get_result(b, total % (1 << aw), (total >= (1 << aw)) ? 1 : 0, delay);
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int total;

        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; acc_ready = 1'b0;
        op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy_a, 1);
        chk("rst_acc_valid", accv_a, 0);
        chk("rst_acc", acc_a, 0);
        chk("rst_overflow", ov_a, 0);
        chk("rst_mult_op1", mop1_a, 0);
        chk("rst_ready_b", rdy_b, 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic batch with consumer always ready: o_acc_valid is a single-cycle pulse.
        acc_ready = 1'b1;
        send(0, 3, 5, 0);
        send(0, 7, 2, 0);
        send(0, 15, 15, 0);
        send(0, 1, 0, 0);
        chk("basic_valid_pre", accv_a, 0);
        @(negedge clk);
        chk("basic_valid", accv_a, 1);
        chk("basic_acc", acc_a, 254);
        chk("basic_overflow", ov_a, 0);
        @(negedge clk);
        chk("basic_valid_pulse", accv_a, 0);
        chk("basic_ready", rdy_a, 1);
        acc_ready = 1'b0;

        // Maximum operands twice in a row: accumulator must restart from zero.
        batch(0, '{15, 15, 15, 15}, '{15, 15, 15, 15}, 4, 0, 0);
        batch(0, '{15, 15, 15, 15}, '{15, 15, 15, 15}, 4, 0, 0);

        // Overflow on the narrow instance, then a clean batch.
        batch(1, '{15, 15, 0, 0}, '{15, 15, 0, 0}, 2, 0, 1);
        batch(1, '{1, 1, 0, 0}, '{1, 1, 0, 0}, 2, 0, 0);

        // Backpressure: offered (9,9) must not be taken while the result is pending.
        for (int i = 0; i < 4; i++) send(0, 2, 3, 0);
        total = 0;
        while (accv_a !== 1'b1 && total < 40) begin
            @(negedge clk);
            total++;
        end
        chk("bp_valid", accv_a, 1);
        chk("bp_acc", acc_a, 24);
        op1 = 4'd9; op2 = 4'd9; valid_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_acc_stable", acc_a, 24);
            chk("bp_ready_low", rdy_a, 0);
            chk("bp_no_accept", mop1_a, 2);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("bp_release_ready", rdy_a, 1);
        chk("bp_release_valid", accv_a, 0);
        @(negedge clk);
        valid_a = 1'b0;
        chk("bp_accept_op1", mop1_a, 9);
        chk("bp_accept_op2", mop2_a, 9);
        chk("bp_accept_busy", rdy_a, 0);
        for (int i = 0; i < 3; i++) send(0, 9, 9, 0);
        get_result(0, 324, 0, 0);

        // Gapped input.
        batch(0, '{3, 7, 15, 1}, '{5, 2, 15, 0}, 4, 3, 0);

        // Asynchronous reset mid-batch, applied between clock edges.
        send(0, 5, 6, 0);
        send(0, 7, 8, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_mult_op1", mop1_a, 0);
        chk("arst_mult_op2", mop2_a, 0);
        chk("arst_ready", rdy_a, 1);
        chk("arst_acc", acc_a, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        batch(0, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 4, 0, 0);

        // Randomized batches on both instances.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = int'($urandom_range(0, 15));
                ys[i] = int'($urandom_range(0, 15));
            end
            batch(0, xs, ys, 4, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            batch(1, xs, ys, 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
